bch_error_injector: RTL and testbench



---
 rtl/bch_pkg.sv | 21 ++
 rtl/bch_lfsr16.sv | 27 ++
 rtl/bch_error_injector.sv | 160 ++++++++++++++++
 tb/tb_bch_error_injector.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared constants, FSM state type and LFSR step function for the BCH demonstrator.
package bch_pkg;

  localparam int          CW_WIDTH          = 14;
  localparam int          DATA_WIDTH        = 8;
  localparam logic [5:0]  BCH_GENERATOR     = 6'b100101;
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    INJECT,
    OUTPUT
  } inj_state_t;

  // Galois right-shift step: taps are folded in when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bch_lfsr16.sv
// 16-bit Galois LFSR with enable; an all-zero seed is replaced by 16'h0001 so the register never locks up.
module bch_lfsr16
  import bch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] r_value;
  logic [15:0] w_seed;

  assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= w_seed;
    end else if (en) begin
      r_value <= lfsr_next(r_value);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/bch_error_injector.sv
// Channel model: flips a clamped number of distinct LFSR-chosen bits in a codeword.
// Optional saturating statistics outputs are enabled by defining BCH_ERR_STATS_EN.
module bch_error_injector
  import bch_pkg::*;
#(
  parameter int          CW_WIDTH   = 14,
  parameter int          POS_W      = 4,
  parameter int          MAX_ERRORS = 3,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CW_WIDTH-1:0] s_codeword,
  input  logic [7:0]          num_errors,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CW_WIDTH-1:0] m_codeword,
  output logic [CW_WIDTH-1:0] m_error_mask,
  output logic                busy
`ifdef BCH_ERR_STATS_EN
  ,
  output logic [15:0]         stat_words,
  output logic [15:0]         stat_bits
`endif
);

  localparam int             LP_CAND_W = 2 ** POS_W;
  localparam logic [POS_W:0] LP_CW     = (POS_W + 1)'(CW_WIDTH);
  localparam logic [7:0]     LP_LIMIT  = (MAX_ERRORS < CW_WIDTH) ? 8'(MAX_ERRORS) : 8'(CW_WIDTH);

  function automatic logic [7:0] clamp_errors(input logic [7:0] n);
    return (n > LP_LIMIT) ? LP_LIMIT : n;
  endfunction

  inj_state_t            r_state;
  inj_state_t            w_state_nxt;
  logic [CW_WIDTH-1:0]   r_cw;
  logic [CW_WIDTH-1:0]   r_mask;
  logic [7:0]            r_errs_left;
  logic [15:0]           w_lfsr;
  logic                  w_lfsr_en;
  logic                  w_accept;
  logic                  w_out_hs;
  logic                  w_cand_ok;
  logic [POS_W-1:0]      w_cand;
  logic [LP_CAND_W-1:0]  w_mask_ext;
  logic [CW_WIDTH-1:0]   w_hit;

  bch_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (w_lfsr_en),
    .seed  (LFSR_SEED),
    .value (w_lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    busy        = 1'b1;
    w_lfsr_en   = 1'b0;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) begin
          w_state_nxt = INJECT;
        end
      end
      INJECT: begin
        if (r_errs_left == 8'd0) begin
          w_state_nxt = OUTPUT;
        end else begin
          w_lfsr_en = 1'b1;
        end
      end
      OUTPUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_accept = s_valid && s_ready;
  assign w_out_hs = m_valid && m_ready;

  // Candidate comes from the low LFSR bits; values past the codeword or already flipped are retried.
  assign w_cand     = POS_W'(w_lfsr);
  assign w_mask_ext = LP_CAND_W'(r_mask);
  assign w_cand_ok  = ({1'b0, w_cand} < LP_CW) && !w_mask_ext[w_cand];
  assign w_hit      = CW_WIDTH'(1) << w_cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cw        <= '0;
      r_mask      <= '0;
      r_errs_left <= 8'd0;
    end else if (w_accept) begin
      r_cw        <= s_codeword;
      r_mask      <= '0;
      r_errs_left <= clamp_errors(num_errors);
    end else if (w_lfsr_en && w_cand_ok) begin
      r_mask      <= r_mask | w_hit;
      r_errs_left <= r_errs_left - 8'd1;
    end
  end

  assign m_codeword   = r_cw ^ r_mask;
  assign m_error_mask = r_mask;

`ifdef BCH_ERR_STATS_EN
  function automatic logic [15:0] popcount(input logic [CW_WIDTH-1:0] v);
    logic [15:0] cnt;
    cnt = 16'd0;
    for (int i = 0; i < CW_WIDTH; i++) begin
      cnt = cnt + 16'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [15:0] r_stat_words;
  logic [15:0] r_stat_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_words <= 16'd0;
      r_stat_bits  <= 16'd0;
    end else if (w_out_hs) begin
      r_stat_words <= sat_add16(r_stat_words, 16'd1);
      r_stat_bits  <= sat_add16(r_stat_bits, popcount(r_mask));
    end
  end

  assign stat_words = r_stat_words;
  assign stat_bits  = r_stat_bits;
`endif

endmodule

// File: tb/tb_bch_error_injector.sv
// Directed bench for bch_error_injector: table of single transactions plus stall, mid-transaction reset and stats sequences.
module tb_bch_error_injector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [13:0] s_codeword = 14'h0000;
  logic [7:0]  num_errors = 8'd0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [13:0] m_codeword;
  logic [13:0] m_error_mask;
  logic        busy;
`ifdef BCH_ERR_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_bits;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bch_error_injector dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_codeword   (s_codeword),
    .num_errors   (num_errors),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_codeword   (m_codeword),
    .m_error_mask (m_error_mask),
    .busy         (busy)
`ifdef BCH_ERR_STATS_EN
    ,
    .stat_words   (stat_words),
    .stat_bits    (stat_bits)
`endif
  );

  typedef struct {
    bit          rst_first;
    logic [13:0] cw;
    logic [7:0]  n;
    logic [13:0] mask;
    logic [13:0] cw_out;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("reset s_ready", 32'(s_ready), 32'd1);
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset mask", 32'(m_error_mask), 32'd0);
  endtask

  // Latency is counted in cycles from the accept cycle T to the first cycle with m_valid high.
  task automatic run_txn(input string name, input logic [13:0] cw, input logic [7:0] n,
                         input logic [13:0] exp_mask, input logic [13:0] exp_cw, input int exp_lat);
    int cnt;
    check({name, " s_ready"}, 32'(s_ready), 32'd1);
    s_codeword = cw;
    num_errors = n;
    s_valid    = 1'b1;
    tick();
    s_valid = 1'b0;
    cnt     = 1;
    while (!m_valid && cnt < 64) begin
      tick();
      cnt++;
    end
    check({name, " latency"}, 32'(cnt), 32'(exp_lat));
    check({name, " mask"}, 32'(m_error_mask), 32'(exp_mask));
    check({name, " codeword"}, 32'(m_codeword), 32'(exp_cw));
    check({name, " popcount"}, 32'($countones(m_error_mask)), 32'($countones(exp_mask)));
    if (m_ready) tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 14'h0000, 8'd3,   14'h0103, 14'h0103, 5};
    vecs[1] = '{1'b0, 14'h3FFF, 8'd3,   14'h1088, 14'h2F77, 6};
    vecs[2] = '{1'b1, 14'h2AAA, 8'd0,   14'h0000, 14'h2AAA, 2};
    vecs[3] = '{1'b0, 14'h0000, 8'd1,   14'h0002, 14'h0002, 3};
    vecs[4] = '{1'b1, 14'h0000, 8'd200, 14'h0103, 14'h0103, 5};

    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].rst_first) do_reset();
      run_txn($sformatf("vec%0d", i), vecs[i].cw, vecs[i].n, vecs[i].mask, vecs[i].cw_out, vecs[i].lat);
    end

    // Back-pressure: outputs frozen while m_ready is low, then a one-cycle handshake.
    do_reset();
    m_ready = 1'b0;
    run_txn("stall", 14'h0000, 8'd200, 14'h0103, 14'h0103, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d m_valid", i), 32'(m_valid), 32'd1);
      check($sformatf("stall%0d mask", i), 32'(m_error_mask), 32'h0103);
      check($sformatf("stall%0d codeword", i), 32'(m_codeword), 32'h0103);
      check($sformatf("stall%0d s_ready", i), 32'(s_ready), 32'd0);
      check($sformatf("stall%0d busy", i), 32'(busy), 32'd1);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("release m_valid", 32'(m_valid), 32'd0);
    check("release s_ready", 32'(s_ready), 32'd1);
    check("release busy", 32'(busy), 32'd0);
    m_ready = 1'b1;

    // Reset one cycle after accept, while INJECT is running.
    do_reset();
    s_codeword = 14'h0000;
    num_errors = 8'd3;
    s_valid    = 1'b1;
    tick();
    s_valid = 1'b0;
    check("midrst busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst m_valid", 32'(m_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst s_ready", 32'(s_ready), 32'd1);
    run_txn("midrst repeat", 14'h0000, 8'd3, 14'h0103, 14'h0103, 5);

`ifdef BCH_ERR_STATS_EN
    do_reset();
    check("stats words reset", 32'(stat_words), 32'd0);
    check("stats bits reset", 32'(stat_bits), 32'd0);
    run_txn("stats t1", 14'h0000, 8'd3, 14'h0103, 14'h0103, 5);
    run_txn("stats t2", 14'h3FFF, 8'd3, 14'h1088, 14'h2F77, 6);
    check("stats words", 32'(stat_words), 32'd2);
    check("stats bits", 32'(stat_bits), 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
